// File: rtl/controller_loop_cfg_issuer.sv
// Loop-configuration issuer: decodes LOOP_CFG / BLOCK_END instructions,
// assigns per-group loop slots in arrival order, issues config strobes,
// starts the block, times the RUN phase and retires the block on done.
module controller_loop_cfg_issuer #(
  parameter int LOOP_ID_W     = 5,
  parameter int GROUP_ID_W    = 2,
  parameter int LOOP_ITER_W   = 16,
  parameter int INST_W        = 32,
  parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_v,
  input  logic [INST_W-1:0]      inst_data,
  output logic                   inst_ready,
  output logic                   cfg_loop_iter_v,
  output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
  output logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
  output logic                   start,
  input  logic                   done,
  output logic                   block_done,
  output logic                   busy,
  output logic                   err,
  output logic [31:0]            run_cycles
);

  localparam int NUM_GROUPS = 1 << GROUP_ID_W;
  // One extra count value marks a group whose slots are all used.
  localparam int CNT_W      = $clog2(NUM_MAX_LOOPS + 1);

  localparam logic [3:0] OP_LOOP_CFG  = 4'h1;
  localparam logic [3:0] OP_BLOCK_END = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    START,
    RUN,
    RETIRE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] exp_cnt_q [NUM_GROUPS];
  logic [CNT_W-1:0] exp_cnt_d [NUM_GROUPS];

  logic                   inst_ready_q, inst_ready_d;
  logic                   cfg_loop_iter_v_q, cfg_loop_iter_v_d;
  logic [LOOP_ITER_W-1:0] cfg_loop_iter_q, cfg_loop_iter_d;
  logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id_q, cfg_loop_iter_loop_id_d;
  logic [GROUP_ID_W-1:0]  cfg_loop_group_id_q, cfg_loop_group_id_d;
  logic                   start_q, start_d;
  logic                   block_done_q, block_done_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [31:0]            run_cycles_q, run_cycles_d;

  // Instruction fields
  logic [3:0]             f_opcode;
  logic [GROUP_ID_W-1:0]  f_group;
  logic [LOOP_ID_W-1:0]   f_loop_id;
  logic [LOOP_ITER_W-1:0] f_iter;
  logic                   accept;
  logic [CNT_W-1:0]       cur_cnt;
  logic                   unused_inst_bits;

  assign f_opcode         = inst_data[31:28];
  assign f_group          = GROUP_ID_W'(inst_data[27:26]);
  assign f_loop_id        = LOOP_ID_W'(inst_data[25:21]);
  assign f_iter           = LOOP_ITER_W'(inst_data[15:0]);
  assign unused_inst_bits = ^inst_data[20:16];

  // ready is registered so it stays low through reset and rises one cycle after release
  assign accept = inst_v & inst_ready_q;

  // Next-state, slot allocation and output computation
  always_comb begin
    state_d                 = state_q;
    exp_cnt_d               = exp_cnt_q;
    cfg_loop_iter_v_d       = 1'b0;
    cfg_loop_iter_d         = cfg_loop_iter_q;
    cfg_loop_iter_loop_id_d = cfg_loop_iter_loop_id_q;
    cfg_loop_group_id_d     = cfg_loop_group_id_q;
    err_d                   = err_q;
    run_cycles_d            = run_cycles_q;
    cur_cnt                 = exp_cnt_q[f_group];

    unique case (state_q)
      // IDLE accepts the first instruction of a block and handles it exactly as CFG would
      IDLE, CFG: begin
        if (accept) begin
          unique case (f_opcode)
            OP_LOOP_CFG: begin
              state_d = CFG;
              if (cur_cnt == CNT_W'(NUM_MAX_LOOPS)) begin
                err_d = 1'b1;
              end else begin
                cfg_loop_iter_v_d       = 1'b1;
                cfg_loop_iter_d         = f_iter;
                cfg_loop_iter_loop_id_d = LOOP_ID_W'(cur_cnt);
                cfg_loop_group_id_d     = f_group;
                if (CNT_W'(f_loop_id) != cur_cnt) begin
                  err_d = 1'b1;
                end
                exp_cnt_d[f_group] = cur_cnt + CNT_W'(1);
              end
            end
            OP_BLOCK_END: begin
              state_d = START;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      START: begin
        state_d      = RUN;
        run_cycles_d = '0;
      end
      RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
        if (done) begin
          state_d = RETIRE;
        end
      end
      RETIRE: begin
        state_d = IDLE;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
          exp_cnt_d[g] = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (done && (state_q != RUN)) begin
      err_d = 1'b1;
    end

    // Pulses derive from the next state so they line up with START/RETIRE
    start_d      = (state_d == START);
    block_done_d = (state_d == RETIRE);
    busy_d       = (state_d != IDLE);
    inst_ready_d = (state_d == IDLE) || (state_d == CFG);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                 <= IDLE;
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        exp_cnt_q[g] <= '0;
      end
      inst_ready_q            <= 1'b0;
      cfg_loop_iter_v_q       <= 1'b0;
      cfg_loop_iter_q         <= '0;
      cfg_loop_iter_loop_id_q <= '0;
      cfg_loop_group_id_q     <= '0;
      start_q                 <= 1'b0;
      block_done_q            <= 1'b0;
      busy_q                  <= 1'b0;
      err_q                   <= 1'b0;
      run_cycles_q            <= '0;
    end else begin
      state_q                 <= state_d;
      exp_cnt_q               <= exp_cnt_d;
      inst_ready_q            <= inst_ready_d;
      cfg_loop_iter_v_q       <= cfg_loop_iter_v_d;
      cfg_loop_iter_q         <= cfg_loop_iter_d;
      cfg_loop_iter_loop_id_q <= cfg_loop_iter_loop_id_d;
      cfg_loop_group_id_q     <= cfg_loop_group_id_d;
      start_q                 <= start_d;
      block_done_q            <= block_done_d;
      busy_q                  <= busy_d;
      err_q                   <= err_d;
      run_cycles_q            <= run_cycles_d;
    end
  end

  assign inst_ready            = inst_ready_q;
  assign cfg_loop_iter_v       = cfg_loop_iter_v_q;
  assign cfg_loop_iter         = cfg_loop_iter_q;
  assign cfg_loop_iter_loop_id = cfg_loop_iter_loop_id_q;
  assign cfg_loop_group_id     = cfg_loop_group_id_q;
  assign start                 = start_q;
  assign block_done            = block_done_q;
  assign busy                  = busy_q;
  assign err                   = err_q;
  assign run_cycles            = run_cycles_q;

endmodule

// File: tb/tb_controller_loop_cfg_issuer.sv
// Directed bench for controller_loop_cfg_issuer.
module tb_controller_loop_cfg_issuer;

  logic        clk;
  logic        reset;
  logic        inst_v;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        cfg_loop_iter_v;
  logic [15:0] cfg_loop_iter;
  logic [4:0]  cfg_loop_iter_loop_id;
  logic [1:0]  cfg_loop_group_id;
  logic        start;
  logic        done;
  logic        block_done;
  logic        busy;
  logic        err;
  logic [31:0] run_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  int strobe_cnt  = 0;
  int start_cnt   = 0;
  int bd_cnt      = 0;
  int overlap_cnt = 0;

  int s0, st0, b0;

  controller_loop_cfg_issuer #(
    .LOOP_ID_W    (5),
    .GROUP_ID_W   (2),
    .LOOP_ITER_W  (16),
    .INST_W       (32),
    .NUM_MAX_LOOPS(32)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .inst_v               (inst_v),
    .inst_data            (inst_data),
    .inst_ready           (inst_ready),
    .cfg_loop_iter_v      (cfg_loop_iter_v),
    .cfg_loop_iter        (cfg_loop_iter),
    .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id),
    .cfg_loop_group_id    (cfg_loop_group_id),
    .start                (start),
    .done                 (done),
    .block_done           (block_done),
    .busy                 (busy),
    .err                  (err),
    .run_cycles           (run_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (cfg_loop_iter_v) strobe_cnt++;
    if (start)           start_cnt++;
    if (block_done)      bd_cnt++;
    if ((32'(cfg_loop_iter_v) + 32'(start) + 32'(block_done)) > 1) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_cfg(input int g, input int id, input int iter);
    logic [1:0]  gg;
    logic [4:0]  ii;
    logic [15:0] it;
    gg = g[1:0];
    ii = id[4:0];
    it = iter[15:0];
    return {4'h1, gg, ii, 5'b0, it};
  endfunction

  function automatic logic [31:0] mk_end();
    return {4'hF, 28'h0};
  endfunction

  task automatic do_reset();
    inst_v = 1'b0;
    done   = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
    tick();
  endtask

  // Called in the cycle where start is high; done arrives run_len cycles later
  task automatic finish_block(input int run_len, input string tag);
    inst_v = 1'b0;
    repeat (run_len) tick();
    check({tag, "_rc_pre"}, 64'(run_cycles), 64'(run_len - 1));
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check({tag, "_bd"}, 64'(block_done), 64'd1);
    check({tag, "_rc"}, 64'(run_cycles), 64'(run_len));
    tick();
    check({tag, "_bd_off"}, 64'(block_done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_rc_hold"}, 64'(run_cycles), 64'(run_len));
  endtask

  initial begin
    reset     = 1'b1;
    inst_v    = 1'b0;
    inst_data = '0;
    done      = 1'b0;
    tick();
    tick();
    // reset state
    check("rst_ready", 64'(inst_ready), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_outs",  64'({cfg_loop_iter_v, start, block_done, cfg_loop_iter,
                            cfg_loop_iter_loop_id, cfg_loop_group_id}), 64'd0);
    check("rst_rc",    64'(run_cycles), 64'd0);
    reset = 1'b0;
    tick();
    check("rel_ready", 64'(inst_ready), 64'd1);

    // back-to-back loop configs then block end
    s0 = strobe_cnt; st0 = start_cnt; b0 = bd_cnt;
    inst_v = 1'b1;
    inst_data = mk_cfg(0, 0, 3);
    tick();
    check("b2b_v0",   64'(cfg_loop_iter_v), 64'd1);
    check("b2b_id0",  64'(cfg_loop_iter_loop_id), 64'd0);
    check("b2b_it0",  64'(cfg_loop_iter), 64'd3);
    check("b2b_busy", 64'(busy), 64'd1);
    inst_data = mk_cfg(0, 1, 7);
    tick();
    check("b2b_v1",  64'(cfg_loop_iter_v), 64'd1);
    check("b2b_id1", 64'(cfg_loop_iter_loop_id), 64'd1);
    check("b2b_it1", 64'(cfg_loop_iter), 64'd7);
    inst_data = mk_end();
    tick();
    check("b2b_start", 64'(start), 64'd1);
    check("b2b_v_off", 64'(cfg_loop_iter_v), 64'd0);
    check("b2b_nrdy",  64'(inst_ready), 64'd0);
    finish_block(10, "b2b");
    check("b2b_nstrb", 64'(strobe_cnt - s0), 64'd2);
    check("b2b_nstart", 64'(start_cnt - st0), 64'd1);
    check("b2b_nbd",   64'(bd_cnt - b0), 64'd1);
    check("b2b_err",   64'(err), 64'd0);

    // interleaved groups
    inst_v = 1'b1;
    inst_data = mk_cfg(1, 0, 5);
    tick();
    check("il_id0", 64'({cfg_loop_iter_v, cfg_loop_group_id, cfg_loop_iter_loop_id}), 64'({1'b1, 2'd1, 5'd0}));
    inst_data = mk_cfg(0, 0, 2);
    tick();
    check("il_id1", 64'({cfg_loop_iter_v, cfg_loop_group_id, cfg_loop_iter_loop_id}), 64'({1'b1, 2'd0, 5'd0}));
    inst_data = mk_cfg(1, 1, 9);
    tick();
    check("il_id2", 64'({cfg_loop_iter_v, cfg_loop_group_id, cfg_loop_iter_loop_id}), 64'({1'b1, 2'd1, 5'd1}));
    check("il_it2", 64'(cfg_loop_iter), 64'd9);
    inst_data = mk_end();
    tick();
    check("il_start", 64'(start), 64'd1);
    finish_block(1, "il");
    check("il_err", 64'(err), 64'd0);

    // wrong loop_id still issued with expected slot
    inst_v = 1'b1;
    inst_data = mk_cfg(0, 3, 11);
    tick();
    check("bad_id_v",   64'(cfg_loop_iter_v), 64'd1);
    check("bad_id_id",  64'(cfg_loop_iter_loop_id), 64'd0);
    check("bad_id_err", 64'(err), 64'd1);
    inst_data = mk_end();
    tick();
    finish_block(2, "bad_id");
    check("bad_id_sticky", 64'(err), 64'd1);
    do_reset();
    check("err_clr", 64'(err), 64'd0);

    // slot overflow in group 2
    s0 = strobe_cnt;
    inst_v = 1'b1;
    for (int i = 0; i < 32; i++) begin
      inst_data = mk_cfg(2, i, 100 + i);
      tick();
    end
    check("ovf_last_id", 64'(cfg_loop_iter_loop_id), 64'd31);
    check("ovf_last_it", 64'(cfg_loop_iter), 64'd131);
    check("ovf_err0",    64'(err), 64'd0);
    inst_data = mk_cfg(2, 0, 500);
    tick();
    check("ovf_v",    64'(cfg_loop_iter_v), 64'd0);
    check("ovf_err",  64'(err), 64'd1);
    check("ovf_hold", 64'(cfg_loop_iter), 64'd131);
    inst_data = mk_end();
    tick();
    check("ovf_start", 64'(start), 64'd1);
    check("ovf_nstrb", 64'(strobe_cnt - s0), 64'd32);
    finish_block(1, "ovf");
    inst_v = 1'b1;
    inst_data = mk_cfg(2, 0, 1);
    tick();
    check("ovf_cleared_id", 64'({cfg_loop_iter_v, cfg_loop_iter_loop_id}), 64'({1'b1, 5'd0}));
    inst_data = mk_end();
    tick();
    finish_block(1, "ovf2");
    do_reset();

    // illegal opcode mid-block, then spurious done in IDLE
    s0 = strobe_cnt;
    inst_v = 1'b1;
    inst_data = mk_cfg(3, 0, 4);
    tick();
    inst_data = {4'h7, 28'h0};
    tick();
    check("ill_v",     64'(cfg_loop_iter_v), 64'd0);
    check("ill_err",   64'(err), 64'd1);
    check("ill_state", 64'({busy, inst_ready, start}), 64'({1'b1, 1'b1, 1'b0}));
    check("ill_hold",  64'({cfg_loop_group_id, cfg_loop_iter}), 64'({2'd3, 16'd4}));
    inst_data = mk_cfg(3, 1, 6);
    tick();
    check("ill_next_id", 64'({cfg_loop_iter_v, cfg_loop_iter_loop_id}), 64'({1'b1, 5'd1}));
    inst_data = mk_end();
    tick();
    finish_block(1, "ill");
    check("ill_nstrb", 64'(strobe_cnt - s0), 64'd2);
    do_reset();
    inst_v = 1'b1;
    inst_data = {4'h7, 28'h0};
    tick();
    inst_v = 1'b0;
    check("ill_idle", 64'({busy, inst_ready, err}), 64'({1'b0, 1'b1, 1'b1}));
    do_reset();
    st0 = start_cnt; b0 = bd_cnt;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("sp_done_err",   64'(err), 64'd1);
    check("sp_done_state", 64'({busy, start, block_done}), 64'd0);
    tick();
    check("sp_done_pulses", 64'({start_cnt - st0, bd_cnt - b0}), 64'd0);

    // reset during RUN aborts the block
    do_reset();
    st0 = start_cnt; b0 = bd_cnt;
    inst_v = 1'b1;
    inst_data = mk_cfg(0, 0, 1);
    tick();
    inst_data = mk_end();
    tick();
    inst_v = 1'b0;
    tick();
    tick();
    check("ab_running", 64'({busy, run_cycles}), 64'({1'b1, 32'd1}));
    reset = 1'b1;
    tick();
    check("ab_outs", 64'({start, block_done, busy, inst_ready, cfg_loop_iter_v}), 64'd0);
    check("ab_rc",   64'(run_cycles), 64'd0);
    reset = 1'b0;
    tick();
    check("ab_ready", 64'(inst_ready), 64'd1);
    check("ab_nbd",   64'(bd_cnt - b0), 64'd0);
    inst_v = 1'b1;
    inst_data = mk_cfg(0, 0, 8);
    tick();
    check("ab_new_id", 64'({cfg_loop_iter_v, cfg_loop_iter_loop_id, cfg_loop_iter}), 64'({1'b1, 5'd0, 16'd8}));
    inst_data = mk_end();
    tick();
    check("ab_start", 64'(start), 64'd1);
    finish_block(3, "ab");
    check("ab_err", 64'(err), 64'd0);

    check("no_overlap", 64'(overlap_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
